// File: rtl/lap_ctl.sv
// lap_ctl: stopwatch lap buffer and display selector with LIVE / FREEZE / BROWSE views.
// Optional feature macro LAP_AUTORETURN_EN adds a HOLD_CYCLES inactivity return to LIVE.
module lap_ctl #(
    parameter int          WIDTH       = 16,
    parameter int          DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     count_enabled,
    input  logic                     init_regs,
    input  logic                     split,
    input  logic                     view,
    input  logic [WIDTH-1:0]         cnt_value,
    output logic [WIDTH-1:0]         disp_value,
    output logic                     disp_lap,
    output logic [$clog2(DEPTH)-1:0] lap_idx,
    output logic [$clog2(DEPTH):0]   lap_count,
    output logic                     lap_full
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] ST_LIVE   = 2'd0;
    localparam logic [1:0] ST_FREEZE = 2'd1;
    localparam logic [1:0] ST_BROWSE = 2'd2;

    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE  = 1;
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lap_ctl: DEPTH must be a power of 2 in 2..16");
    end
    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("lap_ctl: HOLD_CYCLES must be at least 2");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W:0]   lap_count_q, lap_count_d;
    logic [IDX_W-1:0] lap_idx_q, lap_idx_d;
    logic [WIDTH-1:0] lap_mem_q [DEPTH];
    logic             capture;
    logic             last_lap;

    assign lap_full = (lap_count_q == FULL_CNT);
    assign capture  = split && count_enabled && !lap_full && !init_regs;
    assign last_lap = (({1'b0, lap_idx_q} + CNT_ONE) == lap_count_q);

`ifdef LAP_AUTORETURN_EN
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] HOLD_ONE  = 32'd1;

    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic        timeout;

    assign timeout = (state_q != ST_LIVE) && (hold_cnt_q == HOLD_LAST);

    // Counts only uninterrupted dwell in a lap view; any accepted input or state change restarts it.
    always_comb begin
        hold_cnt_d = '0;
        if (state_q != ST_LIVE && state_d == state_q && !capture && !view) begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        lap_count_d = lap_count_q;
        lap_idx_d   = lap_idx_q;
        if (init_regs) begin
            state_d     = ST_LIVE;
            lap_count_d = '0;
            lap_idx_d   = '0;
        end else if (capture) begin
            state_d     = ST_FREEZE;
            lap_count_d = lap_count_q + CNT_ONE;
            lap_idx_d   = lap_count_q[IDX_W-1:0];
        end else if (view) begin
            case (state_q)
                ST_LIVE: begin
                    if (lap_count_q != '0) begin
                        state_d   = ST_BROWSE;
                        lap_idx_d = '0;
                    end
                end
                ST_BROWSE: begin
                    if (last_lap) begin
                        state_d   = ST_LIVE;
                        lap_idx_d = '0;
                    end else begin
                        lap_idx_d = lap_idx_q + IDX_ONE;
                    end
                end
                default: begin
                    state_d   = ST_LIVE;
                    lap_idx_d = '0;
                end
            endcase
        end
`ifdef LAP_AUTORETURN_EN
        else if (timeout) begin
            state_d   = ST_LIVE;
            lap_idx_d = '0;
        end
`endif
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LIVE;
            lap_count_q <= '0;
            lap_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            lap_count_q <= lap_count_d;
            lap_idx_q   <= lap_idx_d;
        end
    end

    // NOTE: the lap memory is deliberately not reset; lap_count alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (capture) begin
            lap_mem_q[lap_count_q[IDX_W-1:0]] <= cnt_value;
        end
    end

    assign disp_lap   = (state_q != ST_LIVE);
    assign disp_value = disp_lap ? lap_mem_q[lap_idx_q] : cnt_value;
    assign lap_idx    = lap_idx_q;
    assign lap_count  = lap_count_q;

endmodule

// File: tb/tb_lap_ctl.sv
// tb_lap_ctl: directed scenarios plus a randomized run against a queue-level lap model.
// Follows the DUT build: define LAP_AUTORETURN_EN for both to exercise the timeout path.
module tb_lap_ctl;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int HOLD  = 8;

    logic             clk = 1'b0;
    logic             reset, count_enabled, init_regs, split, view;
    logic [WIDTH-1:0] cnt_value, disp_value;
    logic             disp_lap, lap_full;
    logic [1:0]       lap_idx;
    logic [2:0]       lap_count;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: stored laps, how many, which one is shown, idle dwell time
    logic [WIDTH-1:0] m_laps [DEPTH];
    int               m_cnt, m_idx, m_idle;
    bit               m_show, m_browse;

    always #5 clk = ~clk;

    lap_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .count_enabled(count_enabled), .init_regs(init_regs),
        .split(split), .view(view), .cnt_value(cnt_value), .disp_value(disp_value),
        .disp_lap(disp_lap), .lap_idx(lap_idx), .lap_count(lap_count), .lap_full(lap_full)
    );

    task automatic step(input logic s, input logic v, input logic i, input logic r);
        split = s; view = v; init_regs = i; reset = r;
        @(posedge clk); #1;
        split = 1'b0; view = 1'b0; init_regs = 1'b0; reset = 1'b0;
    endtask

    task automatic capture(input logic [WIDTH-1:0] val);
        cnt_value = val;
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_clear();
        m_cnt = 0; m_idx = 0; m_idle = 0; m_show = 0; m_browse = 0;
    endtask

    task automatic model_update(input logic r, input logic i, input logic s, input logic v,
                                input logic e, input logic [WIDTH-1:0] c);
        if (r || i) begin
            model_clear();
        end else if (s && e && m_cnt < DEPTH) begin
            m_laps[m_cnt] = c; m_idx = m_cnt; m_cnt++;
            m_show = 1; m_browse = 0; m_idle = 0;
        end else if (v) begin
            if (!m_show) begin
                if (m_cnt > 0) begin m_show = 1; m_browse = 1; m_idx = 0; end
            end else if (!m_browse || m_idx == m_cnt - 1) begin
                m_show = 0; m_browse = 0; m_idx = 0;
            end else begin
                m_idx++;
            end
            m_idle = 0;
        end else if (m_show) begin
            m_idle++;
`ifdef LAP_AUTORETURN_EN
            if (m_idle == HOLD) begin m_show = 0; m_browse = 0; m_idx = 0; m_idle = 0; end
`endif
        end
    endtask

    task automatic test_reset();
        cnt_value = 16'hBEEF; count_enabled = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (disp_lap !== 1'b0) begin n_bad++; $display("FAIL reset_disp_lap: got %b want 0", disp_lap); end
        n_cmp++; if (lap_count !== 3'd0) begin n_bad++; $display("FAIL reset_lap_count: got %0d want 0", lap_count); end
        n_cmp++; if (lap_idx !== 2'd0) begin n_bad++; $display("FAIL reset_lap_idx: got %0d want 0", lap_idx); end
        n_cmp++; if (lap_full !== 1'b0) begin n_bad++; $display("FAIL reset_lap_full: got %b want 0", lap_full); end
        n_cmp++; if (disp_value !== 16'hBEEF) begin n_bad++; $display("FAIL reset_disp_value: got %h want beef", disp_value); end
        // reset in the middle of BROWSE, with every other request asserted
        capture(16'h0011); capture(16'h0022);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (disp_lap !== 1'b1) begin n_bad++; $display("FAIL reset_pre_browse: got %b want 1", disp_lap); end
        cnt_value = 16'h5A5A;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (disp_lap !== 1'b0 || lap_count !== 3'd0 || disp_value !== 16'h5A5A) begin
            n_bad++; $display("FAIL reset_mid_browse: got lap=%b cnt=%0d val=%h want 0/0/5a5a", disp_lap, lap_count, disp_value);
        end
    endtask

    task automatic test_single_capture();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        count_enabled = 1'b0;
        capture(16'h0777);
        n_cmp++; if (lap_count !== 3'd0 || disp_lap !== 1'b0) begin
            n_bad++; $display("FAIL split_disabled: got cnt=%0d lap=%b want 0/0", lap_count, disp_lap);
        end
        count_enabled = 1'b1;
        capture(16'h0123);
        n_cmp++; if (disp_value !== 16'h0123) begin n_bad++; $display("FAIL capture_value: got %h want 0123", disp_value); end
        n_cmp++; if (disp_lap !== 1'b1 || lap_idx !== 2'd0 || lap_count !== 3'd1) begin
            n_bad++; $display("FAIL capture_flags: got lap=%b idx=%0d cnt=%0d want 1/0/1", disp_lap, lap_idx, lap_count);
        end
        cnt_value = 16'h0999;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (disp_value !== 16'h0123) begin n_bad++; $display("FAIL capture_frozen: got %h want 0123", disp_value); end
    endtask

    task automatic test_full();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            capture(16'(k * 16));
            n_cmp++; if (lap_idx !== 2'(k - 1) || lap_count !== 3'(k)) begin
                n_bad++; $display("FAIL full_fill%0d: got idx=%0d cnt=%0d want %0d/%0d", k, lap_idx, lap_count, k - 1, k);
            end
        end
        capture(16'h0050);
        n_cmp++; if (lap_full !== 1'b1 || lap_count !== 3'd4) begin
            n_bad++; $display("FAIL full_sat: got full=%b cnt=%0d want 1/4", lap_full, lap_count);
        end
        n_cmp++; if (disp_value !== 16'h0040 || lap_idx !== 2'd3) begin
            n_bad++; $display("FAIL full_buf3: got val=%h idx=%0d want 0040/3", disp_value, lap_idx);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (disp_value !== 16'((k + 1) * 16) || lap_idx !== 2'(k)) begin
                n_bad++; $display("FAIL full_browse%0d: got val=%h idx=%0d want %h/%0d", k, disp_value, lap_idx, 16'((k + 1) * 16), k);
            end
        end
    endtask

    task automatic test_browse();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cnt_value = 16'h0333;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (disp_lap !== 1'b0) begin n_bad++; $display("FAIL browse_empty: got %b want 0", disp_lap); end
        capture(16'h00A1); capture(16'h00B2);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (disp_lap !== 1'b0) begin n_bad++; $display("FAIL browse_freeze_exit: got %b want 0", disp_lap); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (lap_idx !== 2'd0 || disp_value !== 16'h00A1 || disp_lap !== 1'b1) begin
            n_bad++; $display("FAIL browse_idx0: got idx=%0d val=%h lap=%b want 0/00a1/1", lap_idx, disp_value, disp_lap);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (lap_idx !== 2'd1 || disp_value !== 16'h00B2) begin
            n_bad++; $display("FAIL browse_idx1: got idx=%0d val=%h want 1/00b2", lap_idx, disp_value);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (disp_lap !== 1'b0 || lap_idx !== 2'd0 || disp_value !== 16'h00B2) begin
            n_bad++; $display("FAIL browse_return: got lap=%b idx=%0d val=%h want 0/0/00b2", disp_lap, lap_idx, disp_value);
        end
    endtask

    task automatic test_split_view_same();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        capture(16'h0100);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        cnt_value = 16'h0777;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (lap_count !== 3'd2 || lap_idx !== 2'd1 || disp_lap !== 1'b1 || disp_value !== 16'h0777) begin
            n_bad++; $display("FAIL split_view: got cnt=%0d idx=%0d lap=%b val=%h want 2/1/1/0777", lap_count, lap_idx, disp_lap, disp_value);
        end
    endtask

    task automatic test_init_browse();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        capture(16'h0001); capture(16'h0002); capture(16'h0003);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        cnt_value = 16'h0444;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (disp_lap !== 1'b0 || lap_count !== 3'd0 || lap_full !== 1'b0 || lap_idx !== 2'd0) begin
            n_bad++; $display("FAIL init_browse: got lap=%b cnt=%0d full=%b idx=%0d want 0/0/0/0", disp_lap, lap_count, lap_full, lap_idx);
        end
    endtask

    task automatic test_hold();
        int lap_cycles;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        capture(16'h0ABC);
        lap_cycles = 0;
        for (int c = 0; c < 40 && disp_lap === 1'b1; c++) begin
            lap_cycles++;
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
`ifdef LAP_AUTORETURN_EN
        n_cmp++; if (lap_cycles != HOLD || disp_lap !== 1'b0 || lap_idx !== 2'd0) begin
            n_bad++; $display("FAIL hold_autoreturn: got %0d lap cycles, lap=%b want %0d then 0", lap_cycles, disp_lap, HOLD);
        end
`else
        n_cmp++; if (lap_cycles != 40 || disp_lap !== 1'b1) begin
            n_bad++; $display("FAIL hold_forever: got %0d lap cycles, lap=%b want 40/1", lap_cycles, disp_lap);
        end
`endif
    endtask

    task automatic test_random();
        logic r, i, s, v, e;
        logic [WIDTH-1:0] c, exp_val;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        model_clear();
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 199) == 0);
            i = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 4) != 0);
            c = WIDTH'($urandom);
            if ($urandom_range(0, 2) == 0) begin s = 1'b0; v = 1'b0; end
            reset = r; init_regs = i; split = s; view = v; count_enabled = e; cnt_value = c;
            @(posedge clk);
            model_update(r, i, s, v, e, c);
            #1;
            exp_val = m_show ? m_laps[m_idx] : c;
            n_cmp++; if (disp_lap !== m_show) begin n_bad++; $display("FAIL rnd_disp_lap@%0d: got %b want %b", n, disp_lap, m_show); end
            n_cmp++; if (disp_value !== exp_val) begin n_bad++; $display("FAIL rnd_disp_value@%0d: got %h want %h", n, disp_value, exp_val); end
            n_cmp++; if (lap_idx !== 2'(m_idx)) begin n_bad++; $display("FAIL rnd_lap_idx@%0d: got %0d want %0d", n, lap_idx, m_idx); end
            n_cmp++; if (lap_count !== 3'(m_cnt)) begin n_bad++; $display("FAIL rnd_lap_count@%0d: got %0d want %0d", n, lap_count, m_cnt); end
            n_cmp++; if (lap_full !== (m_cnt == DEPTH)) begin n_bad++; $display("FAIL rnd_lap_full@%0d: got %b want %b", n, lap_full, m_cnt == DEPTH); end
        end
        reset = 1'b0; init_regs = 1'b0; split = 1'b0; view = 1'b0; count_enabled = 1'b1;
    endtask

    initial begin
        reset = 1'b1; count_enabled = 1'b1; init_regs = 1'b0;
        split = 1'b0; view = 1'b0; cnt_value = '0;
        test_reset();
        test_single_capture();
        test_full();
        test_browse();
        test_split_view_same();
        test_init_browse();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
